// File: rtl/resistor_damping_bank_pkg.sv
// rtl/resistor_damping_bank_pkg.sv - shared constants and elaboration helpers for the damping bank
package resistor_damping_bank_pkg;

  localparam int MAX_CHANNELS    = 64;
  localparam int MAX_SYNC_STAGES = 3;
  localparam int MAX_SETTLE      = 255;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Settle counter width; a one-bit counter is kept even for SETTLE=1.
  function automatic int cnt_width(input int settle);
    return (clog2(settle + 1) < 1) ? 1 : clog2(settle + 1);
  endfunction

  function automatic bit params_ok(input int channels, input int sync_stages, input int settle);
    return (channels >= 1) && (channels <= MAX_CHANNELS) &&
           (sync_stages >= 0) && (sync_stages <= MAX_SYNC_STAGES) &&
           (settle >= 0) && (settle <= MAX_SETTLE);
  endfunction

endpackage

// File: rtl/resistor_damping_channel.sv
// rtl/resistor_damping_channel.sv - one line: synchroniser, settle counter, filtered output and change pulse
module resistor_damping_channel
  import resistor_damping_bank_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   SETTLE      = 2,
  parameter logic RESET_BIT   = 1'b1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic I,
  output logic O,
  output logic CHANGED,
  output logic BUSY
);

  localparam int            CW   = cnt_width(SETTLE);
  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

  logic          s;
  logic [CW-1:0] cnt;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = I;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        sync_q <= {SYNC_STAGES{RESET_BIT}};
      end else begin
        sync_q[0] <= I;
        for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
    end

    assign s = sync_q[SYNC_STAGES-1];
  end

  // Any sample that agrees with O restarts the count, so only an unbroken run updates O.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      O       <= RESET_BIT;
      cnt     <= '0;
      CHANGED <= 1'b0;
    end else if (s != O) begin
      if (cnt == LAST) begin
        O       <= s;
        cnt     <= '0;
        CHANGED <= 1'b1;
      end else begin
        cnt     <= cnt + CW'(1);
        CHANGED <= 1'b0;
      end
    end else begin
      cnt     <= '0;
      CHANGED <= 1'b0;
    end
  end

  assign BUSY = |cnt;

endmodule

// File: rtl/resistor_damping_bank.sv
// rtl/resistor_damping_bank.sv - multi-channel synchronising glitch filter modelling a damping resistor pack
module resistor_damping_bank
  import resistor_damping_bank_pkg::*;
#(
  parameter int                  CHANNELS    = 8,
  parameter int                  OHMS        = 0,
  parameter int                  SYNC_STAGES = 2,
  parameter int                  SETTLE      = 2,
  parameter logic [CHANNELS-1:0] RESET_VAL   = {CHANNELS{1'b1}}
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [CHANNELS-1:0] I,
  output logic [CHANNELS-1:0] O,
  output logic [CHANNELS-1:0] CHANGED,
  output logic                BUSY
);

  if (!params_ok(CHANNELS, SYNC_STAGES, SETTLE) || (OHMS < 0)) begin : g_param_check
    $fatal(1, "resistor_damping_bank: CHANNELS, SYNC_STAGES, SETTLE or OHMS out of range");
  end

  if (SETTLE == 0) begin : g_bypass
    // Pure wire: clock and reset are intentionally not used.
    logic unused_clk_rst;
    assign unused_clk_rst = CLK ^ RESET;
    assign O       = I;
    assign CHANGED = '0;
    assign BUSY    = 1'b0;
  end else begin : g_filter
    logic [CHANNELS-1:0] busy_ch;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      resistor_damping_channel #(
        .SYNC_STAGES (SYNC_STAGES),
        .SETTLE      (SETTLE),
        .RESET_BIT   (RESET_VAL[g])
      ) u_ch (
        .CLK     (CLK),
        .RESET   (RESET),
        .I       (I[g]),
        .O       (O[g]),
        .CHANGED (CHANGED[g]),
        .BUSY    (busy_ch[g])
      );
    end

    assign BUSY = |busy_ch;
  end

endmodule

// File: tb/tb_resistor_damping_bank.sv
// tb/tb_resistor_damping_bank.sv - randomized and directed bench for resistor_damping_bank
module tb_resistor_damping_bank;

  localparam int ND = 5;

  function automatic int settle_of(input int d);
    case (d)
      0:       return 2;
      1:       return 4;
      2:       return 3;
      3:       return 8;
      default: return 1;
    endcase
  endfunction

  function automatic int sync_of(input int d);
    return (d == 4) ? 0 : 2;
  endfunction

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] din  [ND];
  logic [7:0] dout [ND];
  logic [7:0] dchg [ND];
  logic       dbusy[ND];
  logic [7:0] zin, zout, zchg;
  logic       zbusy;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  for (genvar d = 0; d < ND; d++) begin : g_dut
    resistor_damping_bank #(
      .CHANNELS(8), .OHMS(33), .SYNC_STAGES(sync_of(d)), .SETTLE(settle_of(d)), .RESET_VAL(8'hFF)
    ) u_dut (
      .CLK(CLK), .RESET(RESET), .I(din[d]), .O(dout[d]), .CHANGED(dchg[d]), .BUSY(dbusy[d])
    );
  end

  resistor_damping_bank #(
    .CHANNELS(8), .OHMS(0), .SYNC_STAGES(3), .SETTLE(0), .RESET_VAL(8'hFF)
  ) u_bypass (
    .CLK(CLK), .RESET(RESET), .I(zin), .O(zout), .CHANGED(zchg), .BUSY(zbusy)
  );

  // Reference: O follows the delayed input after SETTLE consecutive disagreeing samples.
  logic [7:0] m_o   [ND];
  logic [7:0] m_chg [ND];
  logic [7:0] m_pipe[ND][3];
  int         m_run [ND][8];

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int d = 0; d < ND; d++) begin
        m_o[d]   = 8'hFF;
        m_chg[d] = 8'h00;
        for (int ch = 0; ch < 8; ch++) m_run[d][ch] = 0;
        for (int st = 0; st < 3; st++) m_pipe[d][st] = 8'hFF;
      end
    end else begin
      for (int d = 0; d < ND; d++) begin
        logic [7:0] s;
        if (sync_of(d) == 0) s = din[d];
        else s = m_pipe[d][sync_of(d)-1];
        for (int ch = 0; ch < 8; ch++) begin
          m_chg[d][ch] = 1'b0;
          if (s[ch] !== m_o[d][ch]) begin
            m_run[d][ch] = m_run[d][ch] + 1;
            if (m_run[d][ch] == settle_of(d)) begin
              m_o[d][ch]   = s[ch];
              m_run[d][ch] = 0;
              m_chg[d][ch] = 1'b1;
            end
          end else begin
            m_run[d][ch] = 0;
          end
        end
        for (int st = sync_of(d) - 1; st >= 1; st--) m_pipe[d][st] = m_pipe[d][st-1];
        if (sync_of(d) > 0) m_pipe[d][0] = din[d];
      end
    end
  end

  function automatic logic m_busy(input int d);
    for (int ch = 0; ch < 8; ch++) if (m_run[d][ch] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic test_reset();
    RESET = 1'b1;
    for (int d = 0; d < ND; d++) din[d] = 8'h00;
    repeat (3) @(negedge CLK);
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (dout[d] !== 8'hFF || dchg[d] !== 8'h00 || dbusy[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold dut%0d: O=%h CHANGED=%h BUSY=%b, want FF 00 0", d, dout[d], dchg[d], dbusy[d]);
      end
    end
    RESET = 1'b0;
    // Sync flops restart from FF, so the first mismatching sample is at the third edge.
    for (int e = 0; e < 6; e++) begin
      @(negedge CLK);
      checks++;
      if (dout[0] !== ((e >= 3) ? 8'h00 : 8'hFF) || dchg[0] !== ((e == 3) ? 8'hFF : 8'h00)) begin
        errors++;
        $display("FAIL reset_release edge %0d: O=%h CHANGED=%h", e, dout[0], dchg[0]);
      end
    end
  endtask

  task automatic test_latency();
    din[1] = 8'hFF;
    repeat (10) @(negedge CLK);
    din[1] = 8'hF7;
    for (int e = 0; e < 8; e++) begin
      @(negedge CLK);
      checks++;
      if (dout[1][3] !== (e < 5) || dchg[1][3] !== (e == 5) || dbusy[1] !== (e >= 2 && e <= 4)) begin
        errors++;
        $display("FAIL latency edge %0d: O3=%b CHANGED3=%b BUSY=%b", e, dout[1][3], dchg[1][3], dbusy[1]);
      end
    end
  endtask

  task automatic test_glitch();
    int low_cycles;
    int pulses;
    din[1] = 8'hFF;
    repeat (10) @(negedge CLK);
    din[1] = 8'hFE;
    for (int c = 0; c < 14; c++) begin
      @(negedge CLK);
      checks++;
      if (dout[1] !== 8'hFF || dchg[1] !== 8'h00 || dbusy[1] !== m_busy(1)) begin
        errors++;
        $display("FAIL glitch3 cycle %0d: O=%h CHANGED=%h BUSY=%b want FF 00 %b", c, dout[1], dchg[1], dbusy[1], m_busy(1));
      end
      if (c == 2) din[1] = 8'hFF;
    end
    checks++;
    if (dbusy[1] !== 1'b0) begin
      errors++;
      $display("FAIL glitch3_busy: BUSY=%b want 0", dbusy[1]);
    end
    low_cycles = 0;
    pulses     = 0;
    din[1] = 8'hFE;
    for (int c = 0; c < 18; c++) begin
      @(negedge CLK);
      if (dout[1][0] === 1'b0) low_cycles++;
      if (dchg[1][0] === 1'b1) pulses++;
      if (c == 3) din[1] = 8'hFF;
    end
    checks++;
    if (low_cycles != 4 || pulses != 2) begin
      errors++;
      $display("FAIL glitch4: O0 low %0d cycles, %0d pulses, want 4 and 2", low_cycles, pulses);
    end
  endtask

  task automatic test_independence();
    int low6, pulses6, busy_seen;
    low6 = 0; pulses6 = 0; busy_seen = 0;
    din[2] = 8'hFF;
    repeat (10) @(negedge CLK);
    din[2] = 8'hBD;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      checks++;
      if (dout[2][1] !== 1'b1 || dchg[2][1] !== 1'b0 || dbusy[2] !== m_busy(2)) begin
        errors++;
        $display("FAIL indep cycle %0d: O1=%b CHANGED1=%b BUSY=%b want 1 0 %b", c, dout[2][1], dchg[2][1], dbusy[2], m_busy(2));
      end
      if (dout[2][6] === 1'b0) low6++;
      if (dchg[2][6] === 1'b1) pulses6++;
      if (dbusy[2] === 1'b1) busy_seen++;
      if (c == 1) din[2][1] = 1'b1;
      if (c == 5) din[2][6] = 1'b1;
    end
    checks++;
    if (low6 != 6 || pulses6 != 2 || busy_seen == 0) begin
      errors++;
      $display("FAIL indep_ch6: O6 low %0d, pulses %0d, busy cycles %0d, want 6 2 >0", low6, pulses6, busy_seen);
    end
  endtask

  task automatic test_reset_mid_settle();
    din[3] = 8'h20;
    repeat (14) @(negedge CLK);
    din[3] = 8'h00;
    repeat (7) @(negedge CLK);
    checks++;
    if (dout[3] !== 8'h20 || dbusy[3] !== 1'b1) begin
      errors++;
      $display("FAIL mid_settle_pre: O=%h BUSY=%b want 20 1", dout[3], dbusy[3]);
    end
    #2 RESET = 1'b1;
    #1;
    checks++;
    if (dout[3] !== 8'hFF || dbusy[3] !== 1'b0 || dchg[3] !== 8'h00) begin
      errors++;
      $display("FAIL mid_settle_async: O=%h BUSY=%b CHANGED=%h want FF 0 00", dout[3], dbusy[3], dchg[3]);
    end
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    for (int e = 0; e < 12; e++) begin
      @(negedge CLK);
      checks++;
      if (dout[3] !== ((e >= 9) ? 8'h00 : 8'hFF) || dchg[3] !== ((e == 9) ? 8'hFF : 8'h00)) begin
        errors++;
        $display("FAIL mid_settle_release edge %0d: O=%h CHANGED=%h", e, dout[3], dchg[3]);
      end
    end
  endtask

  task automatic test_bypass();
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      zin = 8'($urandom);
      if (c == 30) RESET = 1'b1;
      if (c == 60) RESET = 1'b0;
      #1;
      checks++;
      if (zout !== zin || zchg !== 8'h00 || zbusy !== 1'b0) begin
        errors++;
        $display("FAIL bypass cycle %0d: O=%h I=%h CHANGED=%h BUSY=%b", c, zout, zin, zchg, zbusy);
      end
      #5;
      checks++;
      if (zout !== zin || zchg !== 8'h00 || zbusy !== 1'b0) begin
        errors++;
        $display("FAIL bypass_post_edge cycle %0d: O=%h I=%h", c, zout, zin);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge CLK);
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (dout[d] !== m_o[d] || dchg[d] !== m_chg[d] || dbusy[d] !== m_busy(d)) begin
          errors++;
          $display("FAIL random dut%0d cycle %0d: O=%h CHANGED=%h BUSY=%b want %h %h %b",
                   d, c, dout[d], dchg[d], dbusy[d], m_o[d], m_chg[d], m_busy(d));
        end
      end
      if (c == 200) begin
        #2 RESET = 1'b1;
        #1;
        for (int d = 0; d < ND; d++) begin
          checks++;
          if (dout[d] !== 8'hFF || dbusy[d] !== 1'b0) begin
            errors++;
            $display("FAIL random_reset dut%0d: O=%h BUSY=%b want FF 0", d, dout[d], dbusy[d]);
          end
        end
      end
      if (c == 203) RESET = 1'b0;
      for (int d = 0; d < ND; d++) begin
        logic [7:0] mask;
        mask = 8'h00;
        for (int b = 0; b < 8; b++) mask[b] = ($urandom_range(0, 5) == 0);
        din[d] = din[d] ^ mask;
      end
    end
  endtask

  initial begin
    RESET = 1'b1;
    zin   = 8'h00;
    for (int d = 0; d < ND; d++) din[d] = 8'h00;
    test_reset();
    test_latency();
    test_glitch();
    test_independence();
    test_reset_mid_settle();
    test_bypass();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
